sudoku_move_sequencer: RTL

- Sequences player moves onto the 4x4 user board once the board generator reports a finished puzzle.
- Collects row, column and value entries from the shared 2-bit in_diff_cell_val input, one entry per enter press.
- Writes the value into the user board only if the target cell is not a given cell.
- After each write, scans the board against the solution one cell per cycle and raises out_solved on a full match.

---
 rtl/sudoku_move_sequencer_if.sv | 32 +++
 rtl/sudoku_move_sequencer.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/sudoku_move_sequencer_if.sv
// Bus between the board generator/player side and the move sequencer.
// The slave modport is the sequencer's view; the master drives the inputs.
interface sudoku_move_sequencer_if #(
    parameter int CELL_W  = 3,
    parameter int N_CELLS = 16
);
    logic                        in_board_ready;
    logic                        in_enter;
    logic [1:0]                  in_diff_cell_val;
    logic [CELL_W*N_CELLS-1:0]   in_real_board;
    logic [N_CELLS-1:0]          in_fill_flag;
    logic [CELL_W*N_CELLS-1:0]   out_user_board;
    logic [2:0]                  out_state;
    logic                        out_row_flag;
    logic                        out_col_flag;
    logic                        out_val_flag;
    logic                        out_check_flag;
    logic                        out_reject;
    logic                        out_solved;

    modport master (
        output in_board_ready, in_enter, in_diff_cell_val, in_real_board, in_fill_flag,
        input  out_user_board, out_state, out_row_flag, out_col_flag,
               out_val_flag, out_check_flag, out_reject, out_solved
    );

    modport slave (
        input  in_board_ready, in_enter, in_diff_cell_val, in_real_board, in_fill_flag,
        output out_user_board, out_state, out_row_flag, out_col_flag,
               out_val_flag, out_check_flag, out_reject, out_solved
    );
endinterface

// File: rtl/sudoku_move_sequencer.sv
// Sudoku move sequencer: collects row/col/value entries from the player,
// writes unlocked cells of the 4x4 user board, then scans the board against
// the solution one cell per cycle and latches a sticky solved flag.
module sudoku_move_sequencer #(
    parameter int CELL_W  = 3,
    parameter int N_CELLS = 16
) (
    input  logic                   in_clka,
    input  logic                   in_restart,
    sudoku_move_sequencer_if.slave bus
);

    typedef enum logic [2:0] {
        WAIT_BOARD = 3'd0,
        GET_ROW    = 3'd1,
        GET_COL    = 3'd2,
        GET_VAL    = 3'd3,
        WRITE      = 3'd4,
        CHECK      = 3'd5,
        SOLVED     = 3'd6
    } state_t;

    state_t                  state;
    state_t                  state_next;
    logic                    enter_q;
    logic                    enter_edge;
    logic [1:0]              row_r;
    logic [1:0]              col_r;
    logic [1:0]              val_r;
    logic [3:0]              cnt;
    logic [CELL_W-1:0]       board [N_CELLS];
    logic [N_CELLS-1:0]      fill_q;
    logic                    reject_q;
    logic                    solved_q;
    logic [3:0]              idx;
    logic                    cell_locked;
    logic [CELL_W-1:0]       write_val;
    logic [CELL_W-1:0]       sol_cell;
    logic                    cell_match;
    logic [CELL_W*N_CELLS-1:0] user_board;

    assign enter_edge  = bus.in_enter & ~enter_q;
    assign idx         = {row_r, col_r};
    assign cell_locked = fill_q[idx];
    assign write_val   = {{(CELL_W-2){1'b0}}, val_r} + CELL_W'(1);
    assign sol_cell    = bus.in_real_board[cnt*CELL_W +: CELL_W];
    assign cell_match  = (board[cnt] == sol_cell);

    // State register
    always_ff @(posedge in_clka or negedge in_restart) begin
        if (!in_restart) begin
            state <= WAIT_BOARD;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode; enter edges outside the entry states fall through unused
    always_comb begin
        state_next = state;
        case (state)
            WAIT_BOARD: if (bus.in_board_ready) state_next = GET_ROW;
            GET_ROW:    if (enter_edge)         state_next = GET_COL;
            GET_COL:    if (enter_edge)         state_next = GET_VAL;
            GET_VAL:    if (enter_edge)         state_next = WRITE;
            WRITE:      state_next = cell_locked ? GET_ROW : CHECK;
            CHECK: begin
                if (!cell_match) begin
                    state_next = GET_ROW;
                end else if (cnt == 4'd15) begin
                    state_next = SOLVED;
                end
            end
            SOLVED:     state_next = SOLVED;
            default:    state_next = WAIT_BOARD;
        endcase
    end

    // Datapath: entry latches, board writes, scan counter and status flags
    always_ff @(posedge in_clka or negedge in_restart) begin
        if (!in_restart) begin
            enter_q  <= 1'b0;
            row_r    <= 2'd0;
            col_r    <= 2'd0;
            val_r    <= 2'd0;
            cnt      <= 4'd0;
            fill_q   <= '0;
            reject_q <= 1'b0;
            solved_q <= 1'b0;
            for (int k = 0; k < N_CELLS; k++) begin
                board[k] <= '0;
            end
        end else begin
            enter_q  <= bus.in_enter;
            reject_q <= (state == WRITE) && cell_locked;
            case (state)
                WAIT_BOARD: begin
                    if (bus.in_board_ready) begin
                        fill_q <= bus.in_fill_flag;
                        for (int k = 0; k < N_CELLS; k++) begin
                            board[k] <= bus.in_fill_flag[k] ?
                                        bus.in_real_board[k*CELL_W +: CELL_W] : '0;
                        end
                    end
                end
                GET_ROW: if (enter_edge) row_r <= bus.in_diff_cell_val;
                GET_COL: if (enter_edge) col_r <= bus.in_diff_cell_val;
                GET_VAL: if (enter_edge) val_r <= bus.in_diff_cell_val;
                WRITE: begin
                    cnt <= 4'd0;
                    if (!cell_locked) begin
                        board[idx] <= write_val;
                    end
                end
                CHECK: begin
                    if (cell_match) begin
                        if (cnt == 4'd15) begin
                            solved_q <= 1'b1;
                        end else begin
                            cnt <= cnt + 4'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Pack the cell array into the flat output bus
    always_comb begin
        user_board = '0;
        for (int k = 0; k < N_CELLS; k++) begin
            user_board[k*CELL_W +: CELL_W] = board[k];
        end
    end

    assign bus.out_user_board = user_board;
    assign bus.out_state      = state;
    assign bus.out_row_flag   = (state == GET_ROW);
    assign bus.out_col_flag   = (state == GET_COL);
    assign bus.out_val_flag   = (state == GET_VAL);
    assign bus.out_check_flag = (state == CHECK);
    assign bus.out_reject     = reject_q;
    assign bus.out_solved     = solved_q;

endmodule
